// File: rtl/round_key_sequencer.sv
// Round-key sequencer: holds a bank of round keys and streams them to the round
// datapath a fixed number of keys per step, in forward or reversed order.
module round_key_sequencer #(
    parameter int KEY_W         = 48,
    parameter int NUM_KEYS      = 48,
    parameter int KEYS_PER_STEP = 6,
    parameter int STEP_W        = ((NUM_KEYS / KEYS_PER_STEP) > 1) ?
                                  $clog2(NUM_KEYS / KEYS_PER_STEP) : 1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           load,
    input  logic [NUM_KEYS*KEY_W-1:0]      round_keys_in,
    input  logic                           start,
    input  logic                           decrypt,
    input  logic                           abort,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [KEYS_PER_STEP*KEY_W-1:0] round_keys_out,
    output logic [STEP_W-1:0]              step_idx,
    output logic                           last_step,
    output logic                           busy,
    output logic                           done
);

    localparam int STEPS = NUM_KEYS / KEYS_PER_STEP;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                           r_state;
    logic [NUM_KEYS*KEY_W-1:0]        r_bank;
    logic                             r_dir;
    logic                             w_selDir;
    logic [STEP_W-1:0]                w_selStep;
    logic [KEYS_PER_STEP*KEY_W-1:0]   w_stepKeys;
    logic                             w_nextIsLast;

    // In IDLE the upcoming step is step 0 in the direction requested on this
    // cycle; in RUN it is the successor of the step being presented.
    always_comb begin
        w_selDir   = (r_state == ST_IDLE) ? decrypt : r_dir;
        w_selStep  = (r_state == ST_IDLE) ? '0 : (r_step_next(step_idx));
        w_stepKeys = '0;
        for (int j = 0; j < KEYS_PER_STEP; j++) begin
            int k;
            k = int'(w_selStep) * KEYS_PER_STEP + j;
            if (w_selDir) begin
                k = NUM_KEYS - 1 - k;
            end
            w_stepKeys[(KEYS_PER_STEP-j)*KEY_W-1 -: KEY_W] = r_bank[(NUM_KEYS-k)*KEY_W-1 -: KEY_W];
        end
        w_nextIsLast = (w_selStep == LAST_STEP);
    end

    function automatic logic [STEP_W-1:0] r_step_next(input logic [STEP_W-1:0] cur);
        return cur + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_bank         <= '0;
            r_dir          <= 1'b0;
            round_keys_out <= '0;
            step_idx       <= '0;
            out_valid      <= 1'b0;
            last_step      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        r_bank <= round_keys_in;
                    end else if (start) begin
                        r_dir          <= decrypt;
                        step_idx       <= '0;
                        round_keys_out <= w_stepKeys;
                        last_step      <= w_nextIsLast;
                        out_valid      <= 1'b1;
                        busy           <= 1'b1;
                        r_state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a transfer landing on the same edge.
                    if (abort) begin
                        out_valid <= 1'b0;
                        last_step <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (out_valid && out_ready) begin
                        if (step_idx == LAST_STEP) begin
                            out_valid <= 1'b0;
                            last_step <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            step_idx       <= w_selStep;
                            round_keys_out <= w_stepKeys;
                            last_step      <= w_nextIsLast;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    last_step <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer: encrypt/decrypt streams, backpressure,
// ignored commands, abort, load/start collision and asynchronous reset.
module tb_round_key_sequencer;

    localparam int KEY_W    = 48;
    localparam int NUM_KEYS = 48;
    localparam int KPS      = 6;
    localparam int STEPS    = NUM_KEYS / KPS;
    localparam int STEP_W   = 3;

    logic                      clk;
    logic                      n_rst;
    logic                      load;
    logic [NUM_KEYS*KEY_W-1:0] round_keys_in;
    logic                      start;
    logic                      decrypt;
    logic                      abort;
    logic                      out_ready;
    logic                      out_valid;
    logic [KPS*KEY_W-1:0]      round_keys_out;
    logic [STEP_W-1:0]         step_idx;
    logic                      last_step;
    logic                      busy;
    logic                      done;

    int assertCount = 0;
    int failCount   = 0;
    int stepsSeen;
    logic [KPS*KEY_W-1:0] heldKeys;

    round_key_sequencer #(
        .KEY_W(KEY_W),
        .NUM_KEYS(NUM_KEYS),
        .KEYS_PER_STEP(KPS)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .load(load),
        .round_keys_in(round_keys_in),
        .start(start),
        .decrypt(decrypt),
        .abort(abort),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .round_keys_out(round_keys_out),
        .step_idx(step_idx),
        .last_step(last_step),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank where key i holds the value base+i.
    function automatic logic [NUM_KEYS*KEY_W-1:0] makeBank(input int base);
        logic [NUM_KEYS*KEY_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_KEYS; i++) v[(NUM_KEYS-i)*KEY_W-1 -: KEY_W] = KEY_W'(base + i);
        return v;
    endfunction

    // Expected contents of step s for a bank built with makeBank(base).
    function automatic logic [KPS*KEY_W-1:0] expStep(input int s, input bit dec, input int base);
        logic [KPS*KEY_W-1:0] v;
        int k;
        v = '0;
        for (int j = 0; j < KPS; j++) begin
            k = dec ? (NUM_KEYS - 1 - (s*KPS + j)) : (s*KPS + j);
            v[(KPS-j)*KEY_W-1 -: KEY_W] = KEY_W'(base + k);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".out_valid"}, 512'(out_valid), 512'(0));
        checkOutput({tag, ".busy"},      512'(busy),      512'(0));
        checkOutput({tag, ".last_step"}, 512'(last_step), 512'(0));
    endtask

    task automatic checkStep(input string tag, input int s, input bit dec, input int base);
        checkOutput({tag, ".out_valid"}, 512'(out_valid),      512'(1));
        checkOutput({tag, ".busy"},      512'(busy),           512'(1));
        checkOutput({tag, ".step_idx"},  512'(step_idx),       512'(s));
        checkOutput({tag, ".keys"},      512'(round_keys_out), 512'(expStep(s, dec, base)));
        checkOutput({tag, ".last_step"}, 512'(last_step),      512'(s == STEPS-1));
        checkOutput({tag, ".done"},      512'(done),           512'(0));
    endtask

    task automatic applyStimulus(input bit doStart, input bit doLoad, input bit dec, input int base);
        start         = doStart;
        load          = doLoad;
        decrypt       = dec;
        round_keys_in = makeBank(base);
        tick();
        start = 1'b0;
        load  = 1'b0;
    endtask

    task automatic runStream(input string tag, input bit dec);
        applyStimulus(1'b1, 1'b0, dec, 0);
        for (int s = 0; s < STEPS; s++) begin
            checkStep($sformatf("%s.step%0d", tag, s), s, dec, 0);
            tick();
        end
        checkOutput({tag, ".done_pulse"}, 512'(done), 512'(1));
        checkIdle({tag, ".after_last"});
        tick();
        checkOutput({tag, ".done_low"}, 512'(done), 512'(0));
    endtask

    initial begin
        n_rst = 1'b0; load = 1'b0; start = 1'b0; decrypt = 1'b0;
        abort = 1'b0; out_ready = 1'b1; round_keys_in = '0;
        #12;
        checkIdle("reset");
        checkOutput("reset.keys", 512'(round_keys_out), 512'(0));
        checkOutput("reset.step_idx", 512'(step_idx), 512'(0));
        checkOutput("reset.done", 512'(done), 512'(0));
        n_rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkIdle($sformatf("idle%0d", c));
            checkOutput($sformatf("idle%0d.done", c), 512'(done), 512'(0));
        end

        $display("[TB] encrypt and decrypt streams");
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkIdle("load");
        runStream("enc", 1'b0);
        runStream("dec", 1'b1);

        $display("[TB] backpressure on step 2");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        stepsSeen = 0;
        for (int s = 0; s < STEPS; s++) begin
            checkStep($sformatf("bp.step%0d", s), s, 1'b0, 0);
            stepsSeen++;
            if (s == 2) begin
                out_ready = 1'b0;
                heldKeys  = round_keys_out;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    checkStep($sformatf("bp.hold%0d", c), 2, 1'b0, 0);
                    checkOutput($sformatf("bp.stable%0d", c), 512'(round_keys_out), 512'(heldKeys));
                end
                out_ready = 1'b1;
            end
            tick();
        end
        checkOutput("bp.count", 512'(stepsSeen), 512'(STEPS));
        checkOutput("bp.done", 512'(done), 512'(1));
        tick();

        $display("[TB] ignored commands and abort");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        for (int s = 0; s < 4; s++) tick();
        checkStep("ign.step4", 4, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 100);
        checkStep("ign.step5", 5, 1'b0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkIdle("abort");
        checkOutput("abort.done", 512'(done), 512'(0));
        tick();
        checkIdle("abort.idle");
        checkOutput("abort.done_next", 512'(done), 512'(0));
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkStep("restart.step0", 0, 1'b0, 0);
        tick();
        checkStep("restart.step1", 1, 1'b0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkIdle("abort2");

        $display("[TB] load/start collision and async reset");
        applyStimulus(1'b1, 1'b1, 1'b1, 100);
        checkIdle("collide");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkStep("newbank.step0", 0, 1'b0, 100);
        tick();
        tick();
        checkStep("newbank.step2", 2, 1'b0, 100);
        #2;
        n_rst = 1'b0;
        #1;
        checkIdle("async");
        checkOutput("async.keys", 512'(round_keys_out), 512'(0));
        checkOutput("async.step_idx", 512'(step_idx), 512'(0));
        tick();
        n_rst = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput("cleared.keys", 512'(round_keys_out), 512'(0));
        checkOutput("cleared.valid", 512'(out_valid), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Registered, parametrised successor to the combinational round-key slice selector feeding the 3DES round pipeline.
- Holds a loaded bank of NUM_KEYS round keys. Streams them to the round datapath KEYS_PER_STEP at a time under a valid/ready handshake.
- Supports encrypt (forward) and decrypt (fully reversed) key order, plus abort.
- Sits between the key-expansion block and the unrolled round stages.

Parameters:
- KEY_W, 48, width of one round key.
- NUM_KEYS, 48, total keys in the bank (3 x 16 for 3DES).
- KEYS_PER_STEP, 6, keys presented per step. Must divide NUM_KEYS; STEPS = NUM_KEYS/KEYS_PER_STEP.
- STEP_W, $clog2(STEPS) (min 1), width of the step index.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- load  in  1  capture round_keys_in into the bank (honoured only in IDLE).
- round_keys_in  in  NUM_KEYS*KEY_W  key 0 in MSBs, key i at [(NUM_KEYS-i)*KEY_W-1 -: KEY_W].
- start  in  1  begin a sequence (IDLE only).
- decrypt  in  1  sampled at start; 1 = reversed key order.
- abort  in  1  synchronous return to IDLE.
- out_ready  in  1  datapath accepts the current step.
- out_valid  out  1  round_keys_out / step_idx are valid.
- round_keys_out  out  KEYS_PER_STEP*KEY_W  slot 0 in MSBs, same packing as input.
- step_idx  out  STEP_W  index of the step currently presented.
- last_step  out  1  high while the final step is presented.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final step is accepted.

Behaviour:
- Reset (async, n_rst=0): state IDLE. Key bank, round_keys_out, step_idx, dir flag cleared to 0. out_valid, last_step, busy, done = 0.
- States:
  - IDLE: bank write enabled.
  - RUN: presenting steps.
  - DONE: single cycle, then IDLE.
- IDLE:
  - load=1: bank <= round_keys_in at the edge; start is ignored that cycle (load has priority).
  - start=1 and load=0: dir <= decrypt, step counter <= 0, go to RUN.
- Step contents: slot j of step s carries bank key k = s*KEYS_PER_STEP + j (encrypt) or NUM_KEYS-1-(s*KEYS_PER_STEP+j) (decrypt).
- Output timing: all outputs are registered. With start sampled at edge t, out_valid=1 with step 0 contents is visible after edge t (latency 1).
- Handshake:
  - Transfer occurs on an edge with out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - After a transfer on a non-final step, the next step is presented after that edge. Back-to-back transfers sustain 1 step/cycle.
- last_step = out_valid && step_idx == STEPS-1.
- Transfer on the final step: go to DONE. out_valid, busy, last_step drop to 0 and done=1 for exactly one cycle, then IDLE.
- start and load during RUN/DONE: ignored. Bank contents are unchanged during a sequence.
- abort=1 in RUN or DONE: next state IDLE, out_valid=0, done=0, no done pulse. The bank is retained. abort has priority over a simultaneous transfer. abort in IDLE has no effect.
- round_keys_out and step_idx retain their last values when out_valid=0; only the out_valid qualifier is meaningful.
- Reset asserted mid-RUN: immediate return to reset values; the bank is cleared and must be reloaded.

Test Plan:
- Reset/idle: hold n_rst=0 then release, drive no stimulus -> all outputs 0, busy=0 for 10 cycles.
- Encrypt stream: load key i = i (48 keys), then start with decrypt=0, out_ready=1 -> 8 consecutive valid steps; step 0 slots = 0..5, step 7 slots = 42..47. last_step is high only on step 7. done pulses one cycle after the step-7 transfer.
- Decrypt stream: same bank, start with decrypt=1 -> step 0 slots = 47,46,45,44,43,42; step 7 slots = 5..0.
- Backpressure: out_ready=0 for 3 cycles on step 2 -> step_idx=2 and round_keys_out stable for all 3 cycles; step 3 appears on the cycle after out_ready returns to 1. Total steps = 8, no skip or duplicate.
- Abort and ignored commands:
  - Pulse load (new bank = 100+i) and start during step 4 -> ignored; step 5 still shows keys 30..35.
  - Then abort with out_ready=1 -> IDLE next cycle, no done pulse.
  - A restart streams from step 0 with the original bank.
- Load/start collision and async reset: load and start in the same IDLE cycle -> bank updated, stays IDLE. Assert n_rst mid-RUN -> outputs 0 immediately, independent of clk.
